// File: rtl/qd1_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qd1_debounce_pkg;

  // Per-channel qualification state; the MSB-free encoding is not relied upon.
  typedef enum logic [1:0] {
    REL_STABLE,
    PRESS_WAIT,
    PRS_STABLE,
    REL_WAIT
  } deb_state_t;

  // 10 ms at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Counter width for a qualification window of n cycles; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qd1_debounce_channel.sv
// Single-bit 2-flop synchronizer plus debounce FSM with qualification counter.
// Latency: raw change to btn_out/pulse is DEBOUNCE_CYCLES+2 clocks when held stable.
// Backpressure: none; the input is sampled every clock and strobes are not held.
module qd1_debounce_channel
  import qd1_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          pressed;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Two-flop synchronizer; resets to the released pad level so no false press follows reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  assign pressed = sync_q[1] ^ ACTIVE_LOW;

  // State, counter, level and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REL_STABLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state: any reversal in a WAIT state falls back to the stable state it came from.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      REL_STABLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS_STABLE;
          btn_d   = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRS_STABLE: begin
        if (!pressed) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (pressed) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL_STABLE;
          btn_d   = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = REL_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_out       = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/qd1_button_debounce.sv
// Multi-channel button synchronizer/debouncer feeding the button PIO in_port.
// Latency: DEBOUNCE_CYCLES+2 clocks from a stable raw change to btn_out and strobes.
// Backpressure: none; channels run independently with no arbitration.
module qd1_button_debounce
  import qd1_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    qd1_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_in        (btn_in[i]),
      .btn_out       (btn_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_qd1_button_debounce.sv
// Directed bench for the button debouncer with a 4-cycle qualification window.
// Latency: press/release expected 6 clocks after the raw edge is first sampled.
// Backpressure: n/a.
module tb_qd1_button_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_out;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pcnt [4];
  int rcnt [4];
  int plast[4];
  int s;
  logic [3:0] btn_seen;
  logic [3:0] pulse_seen;
  logic [3:0] overlap;

  qd1_button_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_out       (btn_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling on the falling edge and logging strobes.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (press_pulse[i]) begin
          pcnt[i]++;
          plast[i] = cyc;
        end
        if (release_pulse[i]) rcnt[i]++;
      end
      btn_seen   |= btn_out;
      pulse_seen |= press_pulse | release_pulse;
      overlap    |= press_pulse & release_pulse;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      pcnt[i]  = 0;
      rcnt[i]  = 0;
      plast[i] = 0;
    end
    btn_seen   = '0;
    pulse_seen = '0;
  endtask

  initial begin
    overlap = '0;
    clr();
    reset   = 1'b1;
    btn_in  = 4'hF;

    // Reset state and quiet period after release.
    tick(3);
    check("rst_btn_out", btn_out, 4'h0);
    check("rst_press", press_pulse, 4'h0);
    check("rst_release", release_pulse, 4'h0);
    reset = 1'b0;
    clr();
    tick(20);
    check("idle_btn_seen", btn_seen, 4'h0);
    check("idle_pulse_seen", pulse_seen, 4'h0);

    // Clean press on channel 0, then release.
    clr();
    btn_in = 4'hE;
    tick(6);
    check("press0_early_btn", btn_out, 4'h0);
    check("press0_early_pulse", press_pulse, 4'h0);
    tick(1);
    check("press0_btn", btn_out, 4'h1);
    check("press0_pulse", press_pulse, 4'h1);
    tick(1);
    check("press0_pulse_end", press_pulse, 4'h0);
    check("press0_btn_hold", btn_out, 4'h1);
    btn_in = 4'hF;
    tick(7);
    check("rel0_pulse", release_pulse, 4'h1);
    check("rel0_btn", btn_out, 4'h0);
    tick(3);

    // Bounce on channel 1, then settle low.
    clr();
    btn_in[1] = 1'b0; tick(2);
    btn_in[1] = 1'b1; tick(2);
    btn_in[1] = 1'b0; tick(2);
    btn_in[1] = 1'b1; tick(2);
    btn_in[1] = 1'b0;
    s = cyc;
    tick(10);
    check("bounce_press_cnt", pcnt[1], 1);
    check("bounce_press_delay", plast[1] - s, 7);
    check("bounce_rel_cnt", rcnt[1], 0);
    check("bounce_btn", btn_out, 4'h2);
    btn_in[1] = 1'b1;
    tick(10);
    check("bounce_released", btn_out, 4'h0);

    // Three-cycle glitch on channel 2 is rejected.
    clr();
    btn_in[2] = 1'b0; tick(3);
    btn_in[2] = 1'b1; tick(10);
    check("glitch_btn_seen", btn_seen, 4'h0);
    check("glitch_press", pcnt[2], 0);
    check("glitch_rel", rcnt[2], 0);

    // Simultaneous press of channels 0 and 3, then release channel 3 only.
    clr();
    btn_in = 4'b0110;
    tick(7);
    check("simul_press", press_pulse, 4'b1001);
    check("simul_btn", btn_out, 4'b1001);
    tick(1);
    btn_in = 4'b1110;
    tick(6);
    check("rel3_early", release_pulse, 4'h0);
    tick(1);
    check("rel3_pulse", release_pulse, 4'b1000);
    check("rel3_btn", btn_out, 4'b0001);
    tick(1);
    check("rel3_pulse_end", release_pulse, 4'h0);

    // Release channel 0, then reset in the middle of a press qualification.
    btn_in = 4'hF;
    tick(10);
    check("pre_rst_btn", btn_out, 4'h0);
    clr();
    btn_in = 4'hE;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midrst_btn", btn_out, 4'h0);
    check("midrst_press", press_pulse, 4'h0);
    tick(3);
    check("midrst_btn_held", btn_out, 4'h0);
    reset = 1'b0;
    tick(6);
    check("postrst_early", press_pulse, 4'h0);
    tick(1);
    check("postrst_press", press_pulse, 4'h1);
    check("postrst_btn", btn_out, 4'h1);
    check("postrst_press_cnt", pcnt[0], 1);

    check("no_overlap", overlap, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
